// File: rtl/sigma_sched_ctrl.sv
// SHA-256 message-schedule sequencer: loads W[0..15], expands W[16..63] through an external
// sigma_stage and streams all 64 words. Define SIGMA_SCHED_CFG_EN for writable sigma constants.
module sigma_sched_ctrl #(
  parameter int DATA_W    = 32,
  parameter int SIGMA_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [5:0]        out_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sigma_run,
  output logic [DATA_W-1:0] sigma_in0,
  output logic [DATA_W-1:0] sigma_in1,
  input  logic [DATA_W-1:0] sigma_out0,
  input  logic [DATA_W-1:0] sigma_out1,
  output logic [31:0]       constant_00_00,
  output logic [31:0]       constant_01_01,
  output logic [31:0]       constant_02_02,
  output logic [31:0]       constant_00_03,
  output logic [31:0]       constant_01_04,
  output logic [31:0]       constant_02_05
`ifdef SIGMA_SCHED_CFG_EN
  ,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_addr,
  input  logic [4:0]        cfg_data
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_OUT} state_t;

  localparam bit         LAT0  = (SIGMA_LAT == 0);
  localparam logic [2:0] LAT_C = 3'(SIGMA_LAT);

  state_t            r_state, w_state_nxt;
  logic [5:0]        r_t;
  logic [2:0]        r_cnt;
  logic              r_done;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [5:0]        r_out_idx;
  logic [DATA_W-1:0] r_sig_in0, r_sig_in1;
  logic [DATA_W-1:0] r_buf [16];

  logic              w_in_hs, w_out_hs, w_sample, w_enter_issue;
  logic [5:0]        w_t_iss;
  logic [DATA_W-1:0] w_sum;

  assign w_in_hs  = in_valid & in_ready;
  assign w_out_hs = r_out_valid & out_ready;
  assign w_sample = ((r_state == S_ISSUE) && LAT0) || ((r_state == S_WAIT) && (r_cnt == LAT_C));
  // buf[t] still holds W[t-16] until this sum overwrites it
  assign w_sum    = sigma_out0 + sigma_out1 + r_buf[r_t[3:0] - 4'd7] + r_buf[r_t[3:0]];
  assign w_enter_issue = (w_state_nxt == S_ISSUE) && (r_state != S_ISSUE);
  // t of the word about to be issued: leaving OUT advances t in the same edge
  assign w_t_iss  = (r_state == S_OUT) ? r_t + 6'd1 : r_t;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start && !r_done) w_state_nxt = S_LOAD;
      S_LOAD:  if ((r_t == 6'd16) && (!r_out_valid || out_ready)) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = LAT0 ? S_OUT : S_WAIT;
      S_WAIT:  if (r_cnt == LAT_C) w_state_nxt = S_OUT;
      S_OUT:   if (out_ready) w_state_nxt = (r_t == 6'd63) ? S_IDLE : S_ISSUE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state != S_IDLE);
    in_ready  = (r_state == S_LOAD) && (r_t < 6'd16) && (!r_out_valid || out_ready);
    sigma_run = (r_state == S_ISSUE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_t         <= '0;
      r_cnt       <= '0;
      r_done      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_idx   <= '0;
      r_sig_in0   <= '0;
      r_sig_in1   <= '0;
    end else begin
      r_done <= (r_state == S_OUT) && out_ready && (r_t == 6'd63);
      case (r_state)
        S_IDLE: if (start && !r_done) r_t <= '0;
        S_LOAD: begin
          if (w_in_hs) begin
            r_out_data  <= in_data;
            r_out_idx   <= r_t;
            r_out_valid <= 1'b1;
            r_t         <= r_t + 6'd1;
          end else if (w_out_hs) begin
            r_out_valid <= 1'b0;
          end
        end
        S_ISSUE: r_cnt <= 3'd1;
        S_WAIT:  r_cnt <= r_cnt + 3'd1;
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (r_t != 6'd63) r_t <= r_t + 6'd1;
          end
        end
        default: ;
      endcase
      if (w_sample) begin
        r_out_data  <= w_sum;
        r_out_idx   <= r_t;
        r_out_valid <= 1'b1;
      end
      if (w_enter_issue) begin
        r_sig_in0 <= r_buf[w_t_iss[3:0] - 4'd15];
        r_sig_in1 <= r_buf[w_t_iss[3:0] - 4'd2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_hs)       r_buf[r_t[3:0]] <= in_data;
    else if (w_sample) r_buf[r_t[3:0]] <= w_sum;
  end

  assign out_data  = r_out_data;
  assign out_idx   = r_out_idx;
  assign out_valid = r_out_valid;
  assign done      = r_done;
  assign sigma_in0 = r_sig_in0;
  assign sigma_in1 = r_sig_in1;

`ifdef SIGMA_SCHED_CFG_EN
  localparam logic [4:0] CST_DEF [6] = '{5'd7, 5'd18, 5'd3, 5'd17, 5'd19, 5'd10};
  logic [4:0] r_cst [6];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 6; i++) r_cst[i] <= CST_DEF[i];
    end else if (cfg_we && (r_state == S_IDLE)) begin
      case (cfg_addr)
        3'd0: r_cst[0] <= cfg_data;
        3'd1: r_cst[1] <= cfg_data;
        3'd2: r_cst[2] <= cfg_data;
        3'd3: r_cst[3] <= cfg_data;
        3'd4: r_cst[4] <= cfg_data;
        3'd5: r_cst[5] <= cfg_data;
        default: ;
      endcase
    end
  end

  assign constant_00_00 = {27'd0, r_cst[0]};
  assign constant_01_01 = {27'd0, r_cst[1]};
  assign constant_02_02 = {27'd0, r_cst[2]};
  assign constant_00_03 = {27'd0, r_cst[3]};
  assign constant_01_04 = {27'd0, r_cst[4]};
  assign constant_02_05 = {27'd0, r_cst[5]};
`else
  assign constant_00_00 = 32'd7;
  assign constant_01_01 = 32'd18;
  assign constant_02_02 = 32'd3;
  assign constant_00_03 = 32'd17;
  assign constant_01_04 = 32'd19;
  assign constant_02_05 = 32'd10;
`endif

endmodule

// File: tb/tb_sigma_sched_ctrl.sv
// Bench for sigma_sched_ctrl: three DUTs (SIGMA_LAT 0, 1, 7) with behavioural sigma units,
// driven by a scenario table plus hand-written reset and cfg sequences.
module tb_sigma_sched_ctrl;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start_v [N];
  logic        in_valid_v [N];
  logic [31:0] in_data_v [N];
  logic        out_ready;
  logic        busy_v [N], done_v [N], in_ready_v [N], out_valid_v [N], sig_run_v [N];
  logic [31:0] out_data_v [N], sig_in0_v [N], sig_in1_v [N], sig_out0_v [N], sig_out1_v [N];
  logic [5:0]  out_idx_v [N];
  logic [31:0] cst_v [N][6];
`ifdef SIGMA_SCHED_CFG_EN
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [4:0]  cfg_data = '0;
`endif

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] ss0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ss1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  for (genvar k = 0; k < N; k++) begin : g_dut
    localparam int L = (k == 0) ? 0 : ((k == 1) ? 1 : 7);
    sigma_sched_ctrl #(.DATA_W(32), .SIGMA_LAT(L)) u_dut (
      .clk(clk), .rst(rst), .start(start_v[k]), .busy(busy_v[k]), .done(done_v[k]),
      .in_data(in_data_v[k]), .in_valid(in_valid_v[k]), .in_ready(in_ready_v[k]),
      .out_data(out_data_v[k]), .out_idx(out_idx_v[k]), .out_valid(out_valid_v[k]),
      .out_ready(out_ready), .sigma_run(sig_run_v[k]),
      .sigma_in0(sig_in0_v[k]), .sigma_in1(sig_in1_v[k]),
      .sigma_out0(sig_out0_v[k]), .sigma_out1(sig_out1_v[k]),
      .constant_00_00(cst_v[k][0]), .constant_01_01(cst_v[k][1]), .constant_02_02(cst_v[k][2]),
      .constant_00_03(cst_v[k][3]), .constant_01_04(cst_v[k][4]), .constant_02_05(cst_v[k][5])
`ifdef SIGMA_SCHED_CFG_EN
      , .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data)
`endif
    );
    // Sigma results are only meaningful exactly L cycles after the run pulse
    logic [7:0] run_sr;
    always @(posedge clk or negedge rst) begin
      if (!rst) run_sr <= '0;
      else      run_sr <= {run_sr[6:0], sig_run_v[k]};
    end
    wire [8:0] w_sr = {run_sr, sig_run_v[k]};
    assign sig_out0_v[k] = w_sr[L] ? ss0(sig_in0_v[k]) : 32'hDEADBEEF;
    assign sig_out1_v[k] = w_sr[L] ? ss1(sig_in1_v[k]) : 32'h0BADF00D;
  end

  typedef struct {
    int gap; int pct; bit poke; int abort_at;
    int exp_words; int exp_runs; int exp_dones;
  } scn_t;

  int lat_of [N] = '{0, 1, 7};
  logic [31:0] blk [16];
  logic [31:0] gold [64];
  logic [31:0] got [N][64];
  int checks = 0, errors = 0, cyc_n = 0;
  int exp_idx [N], words [N], runs [N], dones [N], last_run [N], feed_idx [N];
  bit prev_stall [N], done_due [N];
  logic [31:0] prev_data [N];
  logic [5:0]  prev_idx [N];
  bit spacing_on;

  task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d got 0x%0h want 0x%0h", name, k, act, exp);
    end
  endtask

  task automatic mon_clear();
    for (int k = 0; k < N; k++) begin
      prev_stall[k] = 0; done_due[k] = 0; exp_idx[k] = 0; words[k] = 0;
      runs[k] = 0; dones[k] = 0; last_run[k] = -1; feed_idx[k] = 0;
    end
  endtask

  task automatic mon();
    for (int k = 0; k < N; k++) begin
      if (prev_stall[k]) begin
        chk("stall_data", k, out_data_v[k], prev_data[k]);
        chk("stall_idx", k, out_idx_v[k], prev_idx[k]);
      end
      if (done_due[k]) chk("done_pulse", k, {done_v[k], busy_v[k]}, 2'b10);
      else if (done_v[k]) chk("no_stray_done", k, done_v[k], 0);
      if (done_v[k]) dones[k]++;
      done_due[k] = 0;
      if (out_valid_v[k] && out_ready) begin
        if (exp_idx[k] < 64) begin
          chk("word_idx", k, out_idx_v[k], exp_idx[k]);
          chk("word_data", k, out_data_v[k], gold[exp_idx[k]]);
          got[k][exp_idx[k]] = out_data_v[k];
          if (exp_idx[k] == 63) done_due[k] = 1;
          exp_idx[k]++;
          words[k]++;
        end else begin
          chk("no_extra_word", k, out_valid_v[k], 0);
        end
      end
      prev_stall[k] = out_valid_v[k] && !out_ready;
      prev_data[k]  = out_data_v[k];
      prev_idx[k]   = out_idx_v[k];
      if (sig_run_v[k]) begin
        runs[k]++;
        if (spacing_on && last_run[k] >= 0)
          chk("issue_spacing", k, cyc_n - last_run[k], lat_of[k] + 2);
        last_run[k] = cyc_n;
      end
      if (in_valid_v[k] && in_ready_v[k]) feed_idx[k]++;
    end
    cyc_n++;
  endtask

  task automatic cyc();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic run_row(input scn_t s);
    bit finished, aborted;
    int it;
    mon_clear();
    spacing_on = (s.pct >= 100);
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) begin start_v[k] = 1'b1; in_valid_v[k] = 1'b0; end
    cyc();
    for (int k = 0; k < N; k++) start_v[k] = 1'b0;
    finished = 0; aborted = 0; it = 0;
    while (!finished && it < 4000) begin
      for (int k = 0; k < N; k++) begin
        start_v[k]    = s.poke && ((it == 40) || done_v[k]);
        in_valid_v[k] = (feed_idx[k] < 16) && ((it % (s.gap + 1)) == 0);
        in_data_v[k]  = (feed_idx[k] < 16) ? blk[feed_idx[k]] : 32'h0;
      end
      out_ready = (s.pct >= 100) ? 1'b1 : (int'($urandom_range(99)) < s.pct);
      cyc();
      it++;
      if (s.abort_at >= 0 && exp_idx[1] == s.abort_at + 1) begin
        rst = 1'b0;
        #1;
        for (int k = 0; k < N; k++) begin
          chk("async_rst_ctl", k, {busy_v[k], out_valid_v[k], sig_run_v[k], done_v[k], in_ready_v[k]}, 0);
          chk("async_rst_out", k, {out_data_v[k], 26'd0, out_idx_v[k]}, 0);
        end
        finished = 1; aborted = 1;
      end else begin
        finished = 1;
        for (int k = 0; k < N; k++) if (dones[k] == 0) finished = 0;
      end
    end
    chk("row_complete", 0, finished, 1);
    for (int k = 0; k < N; k++) begin
      start_v[k] = 1'b0; in_valid_v[k] = 1'b0;
      if (s.abort_at < 0 || k == 1) begin
        chk("row_words", k, words[k], s.exp_words);
        chk("row_runs", k, runs[k], s.exp_runs);
        chk("row_dones", k, dones[k], s.exp_dones);
      end
      if (s.poke) chk("start_in_done_ignored", k, busy_v[k], 0);
    end
    if (aborted) begin
      @(negedge clk);
      rst = 1'b1;
      mon_clear();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_consts(input string name, input logic [31:0] c0);
    for (int k = 0; k < N; k++) begin
      chk(name, k, cst_v[k][0], c0);
      chk("const_01_01", k, cst_v[k][1], 18);
      chk("const_02_02", k, cst_v[k][2], 3);
      chk("const_00_03", k, cst_v[k][3], 17);
      chk("const_01_04", k, cst_v[k][4], 19);
      chk("const_02_05", k, cst_v[k][5], 10);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    scn_t tbl [7];
    tbl[0] = '{0, 100, 1'b0, -1, 64, 48, 1};  // abc block, sink always ready
    tbl[1] = '{0, 50,  1'b0, -1, 64, 48, 1};  // random back-pressure
    tbl[2] = '{3, 100, 1'b0, -1, 64, 48, 1};  // in_valid 1 on / 3 off
    tbl[3] = '{0, 100, 1'b1, -1, 64, 48, 1};  // start while busy and in done cycle
    tbl[4] = '{0, 100, 1'b0, -1, 64, 48, 1};  // start one cycle after done
    tbl[5] = '{0, 100, 1'b0, 30, 31, 15, 0};  // reset after idx 30 handshake
    tbl[6] = '{0, 100, 1'b0, -1, 64, 48, 1};  // fresh block after reset

    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
    for (int t = 0; t < 64; t++)
      gold[t] = (t < 16) ? blk[t] : ss1(gold[t-2]) + gold[t-7] + ss0(gold[t-15]) + gold[t-16];

    for (int k = 0; k < N; k++) begin
      start_v[k] = 1'b0; in_valid_v[k] = 1'b0; in_data_v[k] = '0;
    end
    out_ready = 1'b1;
    mon_clear();
    spacing_on = 0;

    #2 rst = 1'b0;
    #10;
    for (int k = 0; k < N; k++) begin
      chk("rst_ctl", k, {busy_v[k], done_v[k], in_ready_v[k], out_valid_v[k], sig_run_v[k]}, 0);
      chk("rst_out_data", k, out_data_v[k], 0);
      chk("rst_out_idx", k, out_idx_v[k], 0);
      chk("rst_sigma_in", k, {sig_in0_v[k], sig_in1_v[k]}, 0);
    end
    chk_consts("const_00_00", 7);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int r = 0; r < 7; r++) begin
      run_row(tbl[r]);
      if (r == 0) begin
        for (int k = 0; k < N; k++) begin
          chk("w16_abc", k, got[k][16], 32'h61626380);
          chk("w17_abc", k, got[k][17], 32'h000F0000);
        end
      end
    end

`ifdef SIGMA_SCHED_CFG_EN
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 5'd9;
    cyc();
    cfg_we = 1'b0;
    chk_consts("cfg_idle_write", 9);
    cfg_we = 1'b1; cfg_addr = 3'd6; cfg_data = 5'd1;
    cyc();
    cfg_we = 1'b0;
    chk_consts("cfg_addr6_ignored", 9);
    for (int k = 0; k < N; k++) start_v[k] = 1'b1;
    cyc();
    for (int k = 0; k < N; k++) start_v[k] = 1'b0;
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 5'd5;
    cyc();
    cfg_we = 1'b0;
    chk_consts("cfg_busy_ignored", 9);
    rst = 1'b0;
    #1;
    chk_consts("cfg_reset_default", 7);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
